load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/common_types_pkg.sv | 24 ++
 rtl/ram_if.sv | 14 +
 rtl/lsu_align.sv | 55 +++++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/common_types_pkg.sv
// Shared types for the load/store unit and its RAM port.
package common_types_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NLANES = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;
  typedef enum logic [1:0] {BYTE, HALF, WORD, ILLEGAL} mem_size_t;
  typedef enum logic [1:0] {RAM_IDLE, RAM_BUSY, RAM_DONE} ram_state_t;

  typedef struct packed {
    logic            write;
    mem_size_t       size;
    logic            is_unsigned;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Half with odd address or word not on a 4-byte boundary.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    return ((size == HALF) && addr_lo[0]) || ((size == WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ram_if.sv
// RAM access port: initiator drives strobes/address/data, target returns data and status.
interface ram_if;
  import common_types_pkg::*;

  logic                ren;
  logic [NLANES-1:0]   wen;
  logic [XLEN-1:0]     addr;
  logic [XLEN-1:0]     store;
  logic [XLEN-1:0]     load;
  ram_state_t          state;

  modport initiator (output ren, wen, addr, store, input load, state);
  modport target    (input ren, wen, addr, store, output load, state);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store lane mask and replication, load lane extract and extension.
module lsu_align
  import common_types_pkg::*;
(
  input  mem_size_t          size,
  input  logic [1:0]         addr_lo,
  input  logic               is_unsigned,
  input  logic [XLEN-1:0]    wdata,
  input  logic [XLEN-1:0]    rword,
  output logic [NLANES-1:0]  lane_mask_c,
  output logic [XLEN-1:0]    store_data_c,
  output logic [XLEN-1:0]    load_data_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Pick the addressed byte and half out of the returned word.
  always_comb begin
    ld_byte = rword[7:0];
    case (addr_lo)
      2'd0:    ld_byte = rword[7:0];
      2'd1:    ld_byte = rword[15:8];
      2'd2:    ld_byte = rword[23:16];
      default: ld_byte = rword[31:24];
    endcase
    ld_half = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  // Size-dependent mask, replication and extension; low address bits below the size are ignored.
  always_comb begin
    lane_mask_c  = '0;
    store_data_c = '0;
    load_data_c  = '0;
    case (size)
      BYTE: begin
        lane_mask_c  = 4'b0001 << addr_lo;
        store_data_c = {4{wdata[7:0]}};
        load_data_c  = is_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      HALF: begin
        lane_mask_c  = 4'b0011 << {addr_lo[1], 1'b0};
        store_data_c = {2{wdata[15:0]}};
        load_data_c  = is_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      WORD: begin
        lane_mask_c  = 4'b1111;
        store_data_c = wdata;
        load_data_c  = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging core requests onto ram_if, with access watchdog.
// Build macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests are rejected with resp_err
// instead of being silently aligned.
module load_store_unit
  import common_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             req_ready,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [XLEN-1:0]  resp_rdata,
  ram_if.initiator         ram_if
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t         state_q, state_d;
  lsu_req_t           req_q, req_d, req_in, align_req;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_d;
  logic [XLEN-1:0]    rdata_d;
  logic               ren_d;
  logic [NLANES-1:0]  wen_d;
  logic [XLEN-1:0]    addr_d, store_d;
  logic [NLANES-1:0]  lane_mask_c;
  logic [XLEN-1:0]    store_data_c, load_data_c;
  logic               misalign_c;

  assign req_in = {req_write, mem_size_t'(req_size), req_unsigned, req_addr, req_wdata};

  // Steering follows the incoming request while idle, the latched one afterwards.
  assign align_req = (state_q == IDLE) ? req_in : req_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_c = is_misaligned(align_req.size, align_req.addr[1:0]);
`else
  assign misalign_c = 1'b0;
`endif

  lsu_align u_align (
    .size         (align_req.size),
    .addr_lo      (align_req.addr[1:0]),
    .is_unsigned  (align_req.is_unsigned),
    .wdata        (align_req.wdata),
    .rword        (ram_if.load),
    .lane_mask_c  (lane_mask_c),
    .store_data_c (store_data_c),
    .load_data_c  (load_data_c)
  );

  // Next state, watchdog count and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    rdata_d = '0;
    ren_d   = 1'b0;
    wen_d   = '0;
    addr_d  = ram_if.addr;
    store_d = ram_if.store;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d = req_in;
          cnt_d = '0;
          if ((align_req.size == ILLEGAL) || misalign_c) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            ren_d   = ~align_req.write;
            wen_d   = align_req.write ? lane_mask_c : '0;
            addr_d  = align_req.addr;
            store_d = store_data_c;
          end
        end
      end
      ACCESS: begin
        if (ram_if.state == RAM_DONE) begin
          state_d = RESP;
          rdata_d = align_req.write ? '0 : load_data_c;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          ren_d   = ~align_req.write;
          wen_d   = align_req.write ? lane_mask_c : '0;
          addr_d  = align_req.addr;
          store_d = store_data_c;
          if (TIMEOUT != 0) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      cnt_q        <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      ram_if.ren   <= 1'b0;
      ram_if.wen   <= '0;
      ram_if.addr  <= '0;
      ram_if.store <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      req_ready    <= (state_d == IDLE);
      resp_valid   <= (state_d == RESP);
      resp_err     <= err_d;
      resp_rdata   <= rdata_d;
      ram_if.ren   <= ren_d;
      ram_if.wen   <= wen_d;
      ram_if.addr  <= addr_d;
      ram_if.store <= store_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a variable-latency RAM model and byte-level reference memory.
module tb_load_store_unit;
  import common_types_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  ram_if ram_bus();

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .ram_if       (ram_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    longint      t_acc;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  longint      cyc = 0;
  int          ram_lat = 0;
  int          ram_cnt;
  logic [31:0] ram_mem [16];
  logic [7:0]  ref_mem [64];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM target: completes lat cycles after a strobe is first seen, commits stores on completion.
  always @(posedge clk) begin
    if (!nrst) begin
      ram_bus.state <= RAM_IDLE;
      ram_bus.load  <= '0;
      ram_cnt       <= 0;
      for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
    end else if (ram_bus.state == RAM_DONE) begin
      ram_bus.state <= RAM_IDLE;
      ram_cnt       <= 0;
    end else if (ram_bus.ren || (ram_bus.wen != 4'b0000)) begin
      if (ram_cnt == ram_lat) begin
        ram_bus.state <= RAM_DONE;
        ram_cnt       <= 0;
        ram_bus.load  <= ram_mem[ram_bus.addr[5:2]];
        if (ram_bus.wen[0]) ram_mem[ram_bus.addr[5:2]][7:0]   <= ram_bus.store[7:0];
        if (ram_bus.wen[1]) ram_mem[ram_bus.addr[5:2]][15:8]  <= ram_bus.store[15:8];
        if (ram_bus.wen[2]) ram_mem[ram_bus.addr[5:2]][23:16] <= ram_bus.store[23:16];
        if (ram_bus.wen[3]) ram_mem[ram_bus.addr[5:2]][31:24] <= ram_bus.store[31:24];
      end else begin
        ram_bus.state <= RAM_BUSY;
        ram_cnt       <= ram_cnt + 1;
      end
    end else begin
      ram_bus.state <= RAM_IDLE;
      ram_cnt       <= 0;
    end
  end

  // Response monitor: every resp_valid pops one expectation.
  always @(negedge clk) begin
    if (nrst && resp_valid) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_resp: got resp_valid err=%0b rdata=%h, required no response", resp_err, resp_rdata);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (resp_err !== e.err || resp_rdata !== e.rdata || (cyc - e.t_acc) != longint'(e.lat) ||
            ram_bus.ren !== 1'b0 || ram_bus.wen !== 4'b0000) begin
          miscompares++;
          $display("FAIL %s: got err=%0b rdata=%h lat=%0d ren=%0b wen=%b, required err=%0b rdata=%h lat=%0d ren=0 wen=0000",
                   e.name, resp_err, resp_rdata, cyc - e.t_acc, ram_bus.ren, ram_bus.wen, e.err, e.rdata, e.lat);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  task automatic wait_ready(input string nm, output bit ok);
    int guard = 0;
    while (req_ready !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    ok = (req_ready === 1'b1);
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_ready: got req_ready=%b, required 1 within 64 cycles", nm, req_ready);
    end
  endtask

  function automatic logic [127:0] reset_view();
    return {23'b0, req_ready, resp_valid, resp_err, resp_rdata,
            ram_bus.ren, ram_bus.wen, ram_bus.addr, ram_bus.store};
  endfunction

  // One request: model the response, push it, drive the request, check the RAM strobes.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input string nm);
    exp_t        e;
    bit          ok, bad;
    int          off, nb, base;
    logic [31:0] val, xst;
    logic [3:0]  xwen;
    wait_ready(nm, ok);
    if (!ok) return;
    off  = int'(a[5:0]);
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = off - (off % nb);
    bad  = (sz == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((off % nb) != 0) bad = 1'b1;
`endif
    e.name  = nm;
    e.t_acc = cyc;
    e.err   = 1'b0;
    e.rdata = '0;
    if (bad) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (lat + 2 > int'(TO)) begin
      e.err = 1'b1;
      e.lat = int'(TO) + 1;
    end else begin
      e.lat = lat + 3;
      if (w) begin
        for (int i = 0; i < nb; i++) ref_mem[base + i] = d[8*i +: 8];
      end else begin
        val = '0;
        for (int i = 0; i < nb; i++) val = val | (32'(ref_mem[base + i]) << (8 * i));
        if (!u && nb < 4 && val[8*nb-1]) val = val | ~((32'd1 << (8 * nb)) - 32'd1);
        e.rdata = val;
      end
    end
    for (int i = 0; i < 4; i++) xwen[i] = w && (i >= base % 4) && (i < base % 4 + nb);
    for (int k = 0; k < 4; k++) xst[8*k +: 8] = d[8*(k % nb) +: 8];

    ram_lat      = lat;
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
    sbq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    if (bad)
      check({nm, "_noaccess"}, {123'b0, ram_bus.ren, ram_bus.wen}, 128'b0);
    else
      check({nm, "_drive"}, {59'b0, ram_bus.ren, ram_bus.wen, ram_bus.addr, (w ? ram_bus.store : 32'h0)},
            {59'b0, !w, xwen, a, (w ? xst : 32'h0)});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int guard;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;

    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", reset_view(), {23'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0});
    nrst = 1'b1;
    @(negedge clk);

    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0, "st_word_100");
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        0, "ld_word_100");
    do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h12345680, 1, "st_byte_103");
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        0, "ld_byte_s_103");
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        2, "ld_byte_u_103");
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h80015A5A, 0, "st_word_8001");
    do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        0, "ld_half_s_102");
    do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        3, "ld_half_u_102");
    do_req(1'b0, 2'd2, 1'b0, 32'h101, 32'h0,        0, "ld_word_101");
    do_req(1'b1, 2'd1, 1'b0, 32'h107, 32'h0000C3A5, 0, "st_half_107");
    do_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0,        0, "ld_word_104");
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        1000, "ld_timeout");
    do_req(1'b1, 2'd2, 1'b0, 32'h108, 32'h55AA55AA, 1000, "st_timeout");
    do_req(1'b0, 2'd2, 1'b0, 32'h108, 32'h0,        6, "ld_done_last");
    do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        0, "ld_illegal");
    do_req(1'b1, 2'd3, 1'b0, 32'h100, 32'hFFFFFFFF, 0, "st_illegal");

    // Reset during the second ACCESS cycle of a slow load.
    wait_ready("rst_abort", ok);
    if (ok) begin
      ram_lat   = 5;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_size  = 2'd2;
      req_addr  = 32'h104;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      check("rst_abort_state", reset_view(), {23'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0});
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      repeat (4) @(negedge clk);
    end
    do_req(1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFEF00D, 0, "st_after_rst");
    do_req(1'b0, 2'd1, 1'b0, 32'h106, 32'h0,        0, "ld_after_rst");

    for (int n = 0; n < 300; n++) begin
      logic [1:0] sz;
      int r, lat;
      sz  = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
      r   = int'($urandom % 10);
      lat = (r < 7) ? int'($urandom % 4) : (r < 9) ? 6 : 1000;
      do_req(1'($urandom % 2), sz, 1'($urandom % 2), 32'h100 + 32'($urandom % 64), $urandom, lat, "rand");
    end

    guard = 0;
    while (sbq.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d responses outstanding, required 0", sbq.size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
